// File: rtl/reverb_delay_master.sv
// reverb_delay_master: circular delay line that uses an Avalon-MM on-chip memory.
// Each accepted sample reads the word written delay_len samples ago, then
// overwrites the current write slot. It then presents the old word downstream.
// Optional feature macro: REVERB_DELAY_CLEAR_EN. When it is defined, the whole
// memory is zero-filled after reset, before the first sample is accepted.
module reverb_delay_master #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     delay_len,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  init_done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic                  avm_clken,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata
);

  typedef enum logic [2:0] {CLEAR, IDLE, RD, WR, OUT} state_t;

`ifdef REVERB_DELAY_CLEAR_EN
  localparam state_t START_STATE = CLEAR;
  localparam logic [ADDR_W:0] CLEAR_END = {1'b1, {ADDR_W{1'b0}}};
  logic [ADDR_W:0] clr_cnt, clr_cnt_next;
`else
  localparam state_t START_STATE = IDLE;
`endif

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
  logic [DATA_W-1:0] sample, sample_next;
  logic [DATA_W-1:0] out_data_next, wdata_next;
  logic [ADDR_W-1:0] addr_next;
  logic              out_valid_next, in_ready_next, init_done_next;
  logic              cs_next, we_next;

  assign avm_clken      = 1'b1;
  assign avm_byteenable = '1;

  // Next-state logic. The bus and handshake outputs are registered, so each
  // state computes the values that must be visible in the following state.
  always_comb begin
    state_next     = state;
    wr_ptr_next    = wr_ptr;
    sample_next    = sample;
    out_data_next  = out_data;
    out_valid_next = out_valid;
    in_ready_next  = in_ready;
    init_done_next = init_done;
    cs_next        = avm_chipselect;
    we_next        = avm_write;
    addr_next      = avm_address;
    wdata_next     = avm_writedata;
`ifdef REVERB_DELAY_CLEAR_EN
    clr_cnt_next   = clr_cnt;
`endif
    case (state)
      CLEAR: begin
`ifdef REVERB_DELAY_CLEAR_EN
        if (clr_cnt == CLEAR_END) begin
          state_next     = IDLE;
          cs_next        = 1'b0;
          we_next        = 1'b0;
          in_ready_next  = 1'b1;
          init_done_next = 1'b1;
        end else begin
          cs_next      = 1'b1;
          we_next      = 1'b1;
          addr_next    = clr_cnt[ADDR_W-1:0];
          wdata_next   = '0;
          clr_cnt_next = clr_cnt + (ADDR_W+1)'(1);
        end
`else
        state_next     = IDLE;
        in_ready_next  = 1'b1;
        init_done_next = 1'b1;
`endif
      end
      IDLE: begin
        in_ready_next  = 1'b1;
        init_done_next = 1'b1;
        cs_next        = 1'b0;
        we_next        = 1'b0;
        if (in_valid && in_ready) begin
          state_next    = RD;
          in_ready_next = 1'b0;
          sample_next   = in_data;
          cs_next       = 1'b1;
          addr_next     = wr_ptr - delay_len;
        end
      end
      RD: begin
        state_next = WR;
        cs_next    = 1'b1;
        we_next    = 1'b1;
        addr_next  = wr_ptr;
        wdata_next = sample;
      end
      WR: begin
        state_next     = OUT;
        out_data_next  = avm_readdata;
        out_valid_next = 1'b1;
        cs_next        = 1'b0;
        we_next        = 1'b0;
        wr_ptr_next    = wr_ptr + ADDR_W'(1);
      end
      OUT: begin
        if (out_valid && out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
          in_ready_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers. Reset discards any sample in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= START_STATE;
      wr_ptr         <= '0;
      sample         <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      in_ready       <= 1'b0;
      init_done      <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
`ifdef REVERB_DELAY_CLEAR_EN
      clr_cnt        <= '0;
`endif
    end else begin
      state          <= state_next;
      wr_ptr         <= wr_ptr_next;
      sample         <= sample_next;
      out_data       <= out_data_next;
      out_valid      <= out_valid_next;
      in_ready       <= in_ready_next;
      init_done      <= init_done_next;
      avm_chipselect <= cs_next;
      avm_write      <= we_next;
      avm_address    <= addr_next;
      avm_writedata  <= wdata_next;
`ifdef REVERB_DELAY_CLEAR_EN
      clr_cnt        <= clr_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_reverb_delay_master.sv
// Testbench for reverb_delay_master: it provides a 1-cycle-latency memory
// slave and an array-based reference delay line.
module tb_reverb_delay_master;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2048;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic [DATA_W-1:0]   in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [ADDR_W-1:0]   delay_len = '0;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                init_done;
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_write;
  logic                avm_clken;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata = '0;

  always #5 clk = ~clk;

  reverb_delay_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .delay_len(delay_len),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .init_done(init_done),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_clken(avm_clken),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata)
  );

  // On-chip memory slave: reads return one cycle later, writes land on the edge.
  bit [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (avm_chipselect && !avm_write) avm_readdata <= mem[avm_address];
    if (avm_chipselect && avm_write)  mem[avm_address] <= avm_writedata;
  end

  // Reference delay line: plain array plus write index, and the accept history.
  bit [DATA_W-1:0]   ref_mem [DEPTH];
  int                ref_wp = 0;
  logic [DATA_W-1:0] hist [$];

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] delay;
    logic [DATA_W-1:0] expected;
  } vec_t;
  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_ctrl"}, 32'({out_valid, in_ready, avm_chipselect, avm_write, init_done}), 32'(0));
    checkOutput({tag, "_addr"}, 32'(avm_address), 32'(0));
    checkOutput({tag, "_wdata"}, 32'(avm_writedata), 32'(0));
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'(0));
    checkOutput({tag, "_static"}, 32'({avm_clken, avm_byteenable}), 32'(3'b111));
  endtask

  // Waits for initialisation after reset release; ends just after a negedge.
  task automatic wait_init();
`ifdef REVERB_DELAY_CLEAR_EN
    int  writes = 0;
    int  cyc = 0;
    bit  prev_last = 0;
    bit  timing_ok = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (init_done) begin
        timing_ok = prev_last;
        break;
      end
      prev_last = 0;
      if (avm_chipselect && avm_write) begin
        if (avm_address != ADDR_W'(writes) || avm_writedata != '0)
          checkOutput("clear_write", 32'({avm_address, avm_writedata}), 32'({ADDR_W'(writes), 16'h0}));
        prev_last = (avm_address == ADDR_W'(DEPTH - 1));
        writes++;
      end
      if (in_ready) checkOutput("clear_in_ready", 32'(in_ready), 32'(0));
    end
    checkOutput("clear_count", 32'(writes), 32'(DEPTH));
    checkOutput("clear_init_timing", 32'(timing_ok), 32'(1));
    checkOutput("clear_in_ready_idle", 32'(in_ready), 32'(1));
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    @(negedge clk);
    checkOutput("init_done_first_edge", 32'(init_done), 32'(1));
    checkOutput("in_ready_idle", 32'(in_ready), 32'(1));
`endif
  endtask

  // One transaction; enters and leaves just after a negedge.
  task automatic applyStimulus(input logic [DATA_W-1:0] x, input logic [ADDR_W-1:0] d,
                               input int stall, input string tag, output logic [DATA_W-1:0] got);
    int cyc = 0;
    int rd_exp, wr_exp;
    logic [DATA_W-1:0] exp;
    got = '0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      checkOutput({tag, "_in_ready_timeout"}, 32'(0), 32'(1));
      return;
    end
    out_ready = (stall == 0);
    in_data   = x;
    delay_len = d;
    in_valid  = 1'b1;
    rd_exp = (ref_wp - int'(d) + DEPTH) % DEPTH;
    exp    = ref_mem[rd_exp];
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    delay_len = ADDR_W'($urandom);
    in_data   = DATA_W'($urandom);
    ref_mem[ref_wp] = x;
    wr_exp = ref_wp;
    ref_wp = (ref_wp + 1) % DEPTH;
    hist.push_back(x);
    @(negedge clk);
    checkOutput({tag, "_rd_ctrl"}, 32'({avm_chipselect, avm_write, in_ready, out_valid}), 32'(4'b1000));
    checkOutput({tag, "_rd_addr"}, 32'(avm_address), 32'(rd_exp));
    @(negedge clk);
    checkOutput({tag, "_wr_ctrl"}, 32'({avm_chipselect, avm_write, in_ready, out_valid}), 32'(4'b1100));
    checkOutput({tag, "_wr_addr"}, 32'(avm_address), 32'(wr_exp));
    checkOutput({tag, "_wr_data"}, 32'(avm_writedata), 32'(x));
    @(negedge clk);
    checkOutput({tag, "_latency3"}, 32'({out_valid, in_ready, avm_chipselect}), 32'(3'b100));
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'(exp));
    got = out_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput({tag, "_stall_hold"}, 32'({out_valid, in_ready, avm_chipselect}), 32'(3'b100));
      checkOutput({tag, "_stall_data"}, 32'(out_data), 32'(exp));
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_back_idle"}, 32'({out_valid, in_ready}), 32'(2'b01));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ref_wp = 0;
    hist.delete();
    wait_init();
  endtask

  initial begin
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] x;
    int old_wp, seen;

    $display("[TB] starting reverb_delay_master test");
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("por");
    do_reset();

    // Delay of 3 on a freshly zeroed/initial memory.
    for (int i = 0; i < 8; i++) begin
      vecs[i].data     = DATA_W'(i + 1);
      vecs[i].delay    = ADDR_W'(3);
      vecs[i].expected = (i < 3) ? DATA_W'(0) : DATA_W'(i - 2);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].data, vecs[i].delay, 0, "table", got);
      checkOutput("table_expected", 32'(got), 32'(vecs[i].expected));
    end

    // Random samples, delays and downstream stalls.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(DATA_W'($urandom), ADDR_W'($urandom_range(0, DEPTH - 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0, "rand", got);
    end

    // Long downstream stall.
    applyStimulus(16'hA5A5, ADDR_W'(1), 10, "stall10", got);

    // Wrap of the write pointer with the maximum delay.
    for (int i = 0; i < 2050; i++) begin
      x = DATA_W'($urandom);
      if (hist.size() >= 2047) begin
        logic [DATA_W-1:0] want;
        want = hist[hist.size() - 2047];
        applyStimulus(x, ADDR_W'(2047), 0, "wrap", got);
        checkOutput("wrap_hist", 32'(got), 32'(want));
      end else begin
        applyStimulus(x, ADDR_W'(2047), 0, "wrap", got);
      end
    end

    // Zero delay returns the sample from a full memory depth earlier.
    for (int i = 0; i < 3; i++) begin
      logic [DATA_W-1:0] want;
      want = hist[hist.size() - 2048];
      applyStimulus(DATA_W'($urandom), ADDR_W'(0), 0, "delay0", got);
      checkOutput("delay0_hist", 32'(got), 32'(want));
    end

    // Reset asserted while the write is on the bus.
    old_wp = ref_wp;
    in_data   = 16'hBEEF;
    delay_len = ADDR_W'(5);
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ref_wp = 0;
    hist.delete();
    wait_init();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("abort_no_out_valid", 32'(seen), 32'(0));
    applyStimulus(16'h1234, ADDR_W'((DEPTH - old_wp) % DEPTH), 0, "after_abort", got);
    applyStimulus(16'h5678, ADDR_W'(1), 0, "after_abort2", got);
    checkOutput("after_abort_prev", 32'(got), 32'(16'h1234));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
